// File: rtl/imem_stream_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN  = 3'd0,
        DATA = 3'd1,
        CHK  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } load_state_t;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_stream_loader_if.sv
// Byte-stream input handshake plus imem write port of the loader.
interface imem_stream_loader_if #(
    parameter int ADDR_W = 8
) ();

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // The loader consumes bytes and drives the imem write port.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    // Byte source / memory side, as seen from outside the loader.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

endinterface

// File: rtl/imem_stream_loader_word_packer.sv
// Packs little-endian bytes into 32-bit words and emits a one-cycle
// word_valid pulse the cycle after the fourth byte of a word arrives.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word_data
);

    localparam logic [1:0] WORD_LAST = 2'(WORD_BYTES - 1);

    logic [1:0]  idx;
    logic [23:0] lanes;

    // The byte currently offered completes a word when the lane index is at the top lane.
    assign last_byte = (idx == WORD_LAST);

    // Lane capture and word emission; clear drops a partial word but lets an already completed one go out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 2'd0;
            lanes      <= 24'd0;
            word_valid <= 1'b0;
            word_data  <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx   <= 2'd0;
                lanes <= 24'd0;
            end else if (byte_valid) begin
                idx <= idx + 2'd1;
                case (idx)
                    2'd0: lanes[7:0]   <= byte_data;
                    2'd1: lanes[15:8]  <= byte_data;
                    2'd2: lanes[23:16] <= byte_data;
                    default: begin
                        word_valid <= 1'b1;
                        word_data  <= {byte_data, lanes};
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Framed byte-stream program loader: length, payload words, XOR checksum.
// Writes the payload into imem and holds the core in reset until a
// complete, checksum-valid image has been written.
module imem_stream_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reload,
    imem_stream_loader_if.slave  bus,
    output logic                 cpu_rst,
    output logic                 load_done,
    output logic                 load_err
);

    localparam int         MAX_WORDS = 2 ** ADDR_W;
    localparam logic [1:0] LEN_LAST  = 2'(LEN_BYTES - 1);

    load_state_t       state, next_state;
    logic [1:0]        len_cnt;
    logic [31:0]       word_len;
    logic [ADDR_W:0]   word_cnt;
    logic [7:0]        chksum;
    logic [ADDR_W-1:0] addr_q;

    logic        accept;
    logic        data_accept;
    logic        last_byte;
    logic        word_valid;
    logic [31:0] word_data;
    logic [31:0] len_full;
    logic [31:0] words_after;

    // Handshake and status decode straight from the state register.
    always_comb begin
        bus.in_ready = ((state == LEN) || (state == DATA) || (state == CHK)) && !reload;
        accept       = bus.in_valid && bus.in_ready;
        data_accept  = accept && (state == DATA);
        len_full     = {bus.in_data, word_len[23:0]};
        words_after  = 32'(word_cnt) + 32'd1;
        cpu_rst      = (state != DONE);
        load_done    = (state == DONE);
        load_err     = (state == ERR);
    end

    assign bus.imem_we    = word_valid;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = word_data;

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (reload),
        .byte_valid (data_accept),
        .byte_data  (bus.in_data),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LEN;
        end else begin
            state <= next_state;
        end
    end

    // Frame sequencing: length field, payload words, checksum byte, then a terminal state.
    always_comb begin
        next_state = state;
        if (reload) begin
            next_state = LEN;
        end else begin
            case (state)
                LEN: begin
                    if (accept && (len_cnt == LEN_LAST)) begin
                        if (len_full == 32'd0) begin
                            next_state = CHK;
                        end else if (len_full > 32'(MAX_WORDS)) begin
                            next_state = ERR;
                        end else begin
                            next_state = DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept && last_byte && (words_after == word_len)) begin
                        next_state = CHK;
                    end
                end
                CHK: begin
                    if (accept) begin
                        next_state = (bus.in_data == chksum) ? DONE : ERR;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    // Length capture, payload checksum, word counting and write-address latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt  <= 2'd0;
            word_len <= 32'd0;
            word_cnt <= '0;
            chksum   <= 8'd0;
            addr_q   <= '0;
        end else if (reload) begin
            len_cnt  <= 2'd0;
            word_len <= 32'd0;
            word_cnt <= '0;
            chksum   <= 8'd0;
        end else if (accept) begin
            if (state == LEN) begin
                word_len[8*len_cnt +: 8] <= bus.in_data;
                len_cnt                  <= len_cnt + 2'd1;
            end else if (state == DATA) begin
                chksum <= chksum ^ bus.in_data;
                if (last_byte) begin
                    addr_q   <= word_cnt[ADDR_W-1:0];
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

endmodule
